// File: rtl/rca_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : rca_multicycle
// Brief    : Multi-cycle ripple-carry adder/subtractor, one CHUNK-bit slice per
//            clock from the LSB, with valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module rca_multicycle #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int C_N  = WIDTH / CHUNK;
  localparam int C_IW = (C_N > 1) ? $clog2(C_N) : 1;
  localparam logic [C_IW-1:0] C_LAST = C_IW'(C_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_carry;
  logic [C_IW-1:0]   r_idx;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [31:0]       w_base;
  logic [CHUNK:0]    w_slice;
  logic              w_last;
  logic              w_ovf;

  assign w_base  = 32'(r_idx) * 32'(CHUNK);
  assign w_slice = {1'b0, r_a[w_base +: CHUNK]} + {1'b0, r_b[w_base +: CHUNK]}
                 + {{CHUNK{1'b0}}, r_carry};
  assign w_last  = (r_idx == C_LAST);
  // Only meaningful on the last slice, whose top bit is the word MSB.
  assign w_ovf   = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_slice[CHUNK-1] ^ w_slice[CHUNK];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[w_base +: CHUNK] <= w_slice[CHUNK-1:0];
          r_carry                <= w_slice[CHUNK];
          if (w_last) begin
            r_cout <= w_slice[CHUNK];
            r_ovf  <= w_ovf;
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rca_multicycle.sv
`default_nettype none
// Testbench for rca_multicycle: 32/4 vector table, scoreboard, corner sequences,
// and random sweeps of 8/8 and 8/1 instances against a reference model.
module tb_rca_multicycle;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  logic        v8, r8, cin8, sub8;
  logic [7:0]  a8, b8;
  logic        rdy1, val1, co1, of1, rdy8, val8, co8, of8;
  logic [7:0]  s1, s8;

  rca_multicycle #(.WIDTH(32), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

  rca_multicycle #(.WIDTH(8), .CHUNK(8)) dut_n1 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy1),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(val1),
    .out_ready(r8), .sum(s1), .cout(co1), .ovf(of1));

  rca_multicycle #(.WIDTH(8), .CHUNK(1)) dut_n8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(val8),
    .out_ready(r8), .sum(s8), .cout(co8), .ovf(of8));

  typedef struct packed {
    logic ov;
    logic co;
    logic [31:0] s;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    exp_t        e;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[11];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: wide add then sign-rule overflow (same-sign operands, different-sign result).
  function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic su);
    logic [31:0] mask, yy;
    logic [32:0] full;
    logic        c;
    exp_t        r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    yy   = (su ? ~y : y) & mask;
    c    = su ? 1'b1 : ci;
    full = {1'b0, x & mask} + {1'b0, yy} + {32'd0, c};
    r.s  = full[31:0] & mask;
    r.co = full[w];
    r.ov = (x[w-1] == yy[w-1]) && (full[w-1] != x[w-1]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic su);
    int t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check("accept_timeout", 32'd0, 32'd1);
    a = x; b = y; cin = ci; sub = su; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic collect(input string name);
    int   lat = 1;
    exp_t e;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, 32'd9);
    if (sbq.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check({name, "_sum"}, sum, e.s);
      check({name, "_cout"}, {31'd0, cout}, {31'd0, e.co});
      check({name, "_ovf"}, {31'd0, ovf}, {31'd0, e.ov});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_rdy_after"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t        e, e1, e8;
    logic [31:0] x, y;
    logic        ci, su, seen, d1, d8;
    int          t, lat;

    tbl[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{1'b0, 1'b1, 32'h0000_0000}};
    tbl[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{1'b1, 1'b0, 32'h8000_0000}};
    tbl[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{1'b1, 1'b1, 32'h7FFF_FFFF}};
    tbl[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, '{1'b0, 1'b0, 32'hFFFF_FFFE}};
    tbl[4]  = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, '{1'b0, 1'b1, 32'h0000_0002}};
    tbl[5]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, '{1'b0, 1'b0, 32'h2345_6789}};
    tbl[6]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, '{1'b0, 1'b0, 32'h0000_0001}};
    tbl[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '{1'b1, 1'b1, 32'h0000_0000}};
    tbl[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, '{1'b0, 1'b1, 32'h0000_0000}};
    tbl[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, '{1'b0, 1'b1, 32'hFFFF_FFFF}};
    tbl[10] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, '{1'b1, 1'b0, 32'h8000_0000}};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    v8 = 1'b0; r8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_sum", sum, 32'd0);
    check("reset_flags", {30'd0, cout, ovf}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      sbq.push_back(tbl[i].e);
      collect($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      x = $urandom; y = $urandom; ci = 1'($urandom); su = 1'($urandom);
      issue(x, y, ci, su);
      sbq.push_back(model(32, x, y, ci, su));
      collect($sformatf("rnd%0d", i));
    end

    // Back-pressure: result must hold while inputs churn, next accept after handshake+1.
    issue(32'h89AB_CDEF, 32'h1234_5678, 1'b1, 1'b0);
    e = model(32, 32'h89AB_CDEF, 32'h1234_5678, 1'b1, 1'b0);
    t = 0;
    while (!out_valid && t < 40) begin
      tick();
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_sum", sum, e.s);
      check("bp_flags", {30'd0, cout, ovf}, {30'd0, e.co, e.ov});
      in_valid = 1'($urandom); a = $urandom; b = $urandom; sub = 1'($urandom);
      tick();
    end
    a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", {30'd0, in_ready, out_valid}, 32'd2);
    tick();
    in_valid = 1'b0;
    check("bp_next_accept", {31'd0, in_ready}, 32'd0);
    sbq.push_back(model(32, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0));
    collect("bp_next");

    // Reset during RUN slice 3 aborts without ever presenting a result.
    issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sum", sum, 32'd0);
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_result", {31'd0, seen}, 32'd0);
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    sbq.push_back('{1'b0, 1'b0, 32'h2345_6789});
    collect("post_rst");

    // Reset coinciding with a result handshake: reset wins, registers clear.
    issue(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
    t = 0;
    while (!out_valid && t < 40) begin
      tick();
      t++;
    end
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    check("done_rst_state", {30'd0, in_ready, out_valid}, 32'd2);
    check("done_rst_sum", sum, 32'd0);

    // Parameter sweep: both 8-bit instances share stimulus.
    for (int i = 0; i < 1000; i++) begin
      x = {24'd0, 8'($urandom)}; y = {24'd0, 8'($urandom)};
      ci = 1'($urandom); su = 1'($urandom);
      t = 0;
      while (!(rdy1 && rdy8) && t < 30) begin
        tick();
        t++;
      end
      if (t >= 30) check("sweep_accept_timeout", 32'd0, 32'd1);
      a8 = x[7:0]; b8 = y[7:0]; cin8 = ci; sub8 = su; v8 = 1'b1;
      tick();
      v8 = 1'b0;
      e1 = model(8, x, y, ci, su);
      e8 = e1;
      lat = 1; d1 = 1'b0; d8 = 1'b0;
      while (!(d1 && d8) && lat < 30) begin
        tick();
        lat++;
        if (val1 && !d1) begin
          d1 = 1'b1;
          check("n1_latency", lat, 32'd2);
          check("n1_sum", {24'd0, s1}, e1.s);
          check("n1_flags", {30'd0, co1, of1}, {30'd0, e1.co, e1.ov});
        end
        if (val8 && !d8) begin
          d8 = 1'b1;
          check("n8_latency", lat, 32'd9);
          check("n8_sum", {24'd0, s8}, e8.s);
          check("n8_flags", {30'd0, co8, of8}, {30'd0, e8.co, e8.ov});
        end
      end
      if (!(d1 && d8)) check("sweep_result_timeout", {30'd0, d1, d8}, 32'd3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rca_multicycle.md
# rca_multicycle

Parametrised multi-cycle ripple-carry adder/subtractor. It computes a WIDTH-bit sum by iterating one CHUNK-bit ripple slice per clock, starting from the LSB slice. This trades latency for area against a flat WIDTH-bit ripple chain. It is the ALU's shared add/sub datapath, with valid/ready handshakes on both operand and result sides, and reports carry-out and signed overflow.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle. N = WIDTH/CHUNK slices, with 1 ≤ N.
- clk  input  1  rising-edge clock; the block's one clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands. High only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add. Ignored when sub=1.
- sub  input  1  0 means A+B+cin; 1 means A−B (A + ~B + 1).
- out_valid  output  1  result is valid. Held until it is accepted.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH−1. For sub, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture a, b' = sub ? ~b : b, and carry = sub ? 1 : cin. Clear the slice index, then go to RUN.
  - RUN: each cycle, add slice i of a and b' plus carry, write sum[i*CHUNK +: CHUNK], update carry, increment i. After slice N−1, latch cout and ovf, then go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Overflow: ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1. Equivalently, a[MSB] ^ b'[MSB] ^ sum[MSB] ^ cout.
- Captured operands are held internally. Input changes after acceptance have no effect.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- sum, cout and ovf keep their values through IDLE until the next operation's RUN begins overwriting them. Only sum/cout/ovf qualified by out_valid are meaningful.
- Slice index counter width: clog2(N), minimum 1 bit. No wrap-around occurs, because RUN exits at index N−1.

## Timing
- Reset: state=IDLE, in_ready=1 in the cycle after rst, out_valid=0, sum=0, cout=0, ovf=0, slice index=0, internal operand/carry registers=0.
- A rst asserted in any state, including mid-RUN or in DONE with out_valid high, aborts the operation next edge. No partial result is ever presented.
- Accept at edge k (in_valid & in_ready sampled high):
  - RUN occupies edges k+1 … k+N.
  - out_valid rises after edge k+N.
- Latency is N+1 cycles, measured from the accept edge to the first cycle with out_valid=1.
- Result handshake completes on an edge with out_valid & out_ready. in_ready is high the following cycle.
- Minimum issue interval is N+2 cycles with out_ready held high. There is no overlap between operations.
- out_valid, sum, cout and ovf are stable while out_valid=1 and out_ready=0.
- If rst and a handshake coincide on the same edge, rst wins.

## Test plan
(WIDTH=32, CHUNK=4 unless stated)
- Carry ripple across all slices: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 → sum=0x00000000, cout=1, ovf=0. out_valid appears exactly 9 cycles after the accept edge.
- Signed overflow:
  - a=0x7FFFFFFF, b=1, add → sum=0x80000000, cout=0, ovf=1.
  - a=0x80000000, b=1, sub → sum=0x7FFFFFFF, cout=1, ovf=1.
- Subtract with borrow and cin ignored: a=5, b=7, sub=1, cin=1 → sum=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5, sub=1 → sum=2, cout=1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid, toggling in_valid/a/b meanwhile. Required: sum/cout/ovf constant, in_ready=0, and the next accept only after the out handshake plus 1 cycle.
- Reset mid-operation: assert rst for 1 cycle during RUN slice 3. Required next cycle: in_ready=1, out_valid=0, sum=0. A following op a=0x12345678, b=0x11111111, add → sum=0x23456789, cout=0.
- Parameter sweep: WIDTH=8 with CHUNK=8 (N=1, latency 2), and WIDTH=8 with CHUNK=1 (N=8, latency 9). Run 1000 random add/sub ops each against a reference model on sum, cout and ovf.
